// File: rtl/pid_seq.sv
// pid_seq: sequences P, D and I term computation for one error sample on a
// single shared 10x5 signed multiplier, then sums the terms into pid.
module pid_seq #(
  parameter logic signed [4:0] P_COEFF = 5'sh08,
  parameter logic signed [4:0] D_COEFF = 5'sh07,
  parameter int                D_DEPTH = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  err_sat,
  input  logic        err_vld,
  input  logic        moving,
  output logic        busy,
  output logic [15:0] pid,
  output logic        pid_vld,
  output logic        ovr
);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL_P = 2'd1, MUL_D = 2'd2, SUM = 2'd3} state_t;

  state_t state_q, state_d;

  logic signed [9:0]          err_q, prev_q;
  logic                       mov_q;
  logic [D_DEPTH-1:0][9:0]    dl_q;      // [0] newest accepted sample
  logic signed [14:0]         p_q, d_q;
  logic signed [17:0]         integ_q;
  logic signed [15:0]         pid_q;
  logic                       pid_vld_q, ovr_q;

  logic signed [9:0]  d_diff;
  logic signed [7:0]  sat8;
  logic signed [9:0]  mul_a;
  logic signed [4:0]  mul_b;
  logic signed [14:0] mul_y;
  logic signed [17:0] int_sum;
  logic               int_ovf;
  logic signed [11:0] i_term;
  logic signed [15:0] pid_sum;

  assign busy    = (state_q != IDLE);
  assign pid     = pid_q;
  assign pid_vld = pid_vld_q;
  assign ovr     = ovr_q;

  // Next-state: only IDLE waits, the rest of the sequence is fixed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (err_vld) state_d = MUL_P;
      MUL_P:   state_d = MUL_D;
      MUL_D:   state_d = SUM;
      SUM:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: derivative saturation, shared multiplier, integrator add, final sum.
  always_comb begin
    d_diff = err_q - prev_q;
    if (d_diff > 10'sd127)       sat8 = 8'sd127;
    else if (d_diff < -10'sd128) sat8 = -8'sd128;
    else                         sat8 = d_diff[7:0];
    // One multiplier: operand A/B pair selected by the step being computed.
    mul_a   = (state_q == MUL_D) ? 10'(sat8) : err_q;
    mul_b   = (state_q == MUL_D) ? D_COEFF   : P_COEFF;
    mul_y   = 15'(mul_a) * 15'(mul_b);
    int_sum = integ_q + 18'(err_q);
    // Same-sign addends producing a different-sign sum means wraparound.
    int_ovf = (integ_q[17] == err_q[9]) && (int_sum[17] != integ_q[17]);
    i_term  = integ_q[17:6];
    pid_sum = 16'(p_q) + 16'(i_term) + 16'(d_q);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Sample capture, delay line, term registers, integrator and outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q     <= '0;
      prev_q    <= '0;
      mov_q     <= 1'b0;
      dl_q      <= '0;
      p_q       <= '0;
      d_q       <= '0;
      integ_q   <= '0;
      pid_q     <= '0;
      pid_vld_q <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      pid_vld_q <= 1'b0;
      ovr_q     <= err_vld && busy;
      case (state_q)
        IDLE: if (err_vld) begin
          err_q  <= err_sat;
          mov_q  <= moving;
          prev_q <= dl_q[D_DEPTH-1];
          for (int i = D_DEPTH-1; i > 0; i--) dl_q[i] <= dl_q[i-1];
          dl_q[0] <= err_sat;
        end
        MUL_P: p_q <= mul_y;
        MUL_D: begin
          d_q <= mul_y;
          if (!mov_q)       integ_q <= '0;
          else if (!int_ovf) integ_q <= int_sum;
        end
        SUM: begin
          pid_q     <= pid_sum;
          pid_vld_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pid_seq.sv
// tb_pid_seq: directed table, overrun/reset/saturation sequences and random
// samples checked against a behavioural PID model.
module tb_pid_seq;
  localparam int PC = 8;
  localparam int DC = 7;
  localparam int DD = 3;

  logic        clk = 1'b0;
  logic        rst_n, err_vld, moving;
  logic [9:0]  err_sat;
  logic        busy, pid_vld, ovr;
  logic [15:0] pid;

  always #5 clk = ~clk;

  pid_seq dut (
    .clk(clk), .rst_n(rst_n), .err_sat(err_sat), .err_vld(err_vld),
    .moving(moving), .busy(busy), .pid(pid), .pid_vld(pid_vld), .ovr(ovr)
  );

  int n_vec = 0;
  int n_err = 0;
  int hist[$];
  int m_integ = 0;

  typedef struct {
    bit rst;
    int err;
    bit mov;
    int exp_pid;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int spid();
    return int'($signed(pid));
  endfunction

  // Behavioural model: history of accepted samples, plain integer math.
  function automatic int model_step(input int e, input bit m);
    int prev, diff, s, isum;
    prev = (hist.size() >= DD) ? hist[hist.size()-DD] : 0;
    hist.push_back(e);
    diff = e - prev;
    if (diff > 511) diff -= 1024;
    else if (diff < -512) diff += 1024;
    s = (diff > 127) ? 127 : ((diff < -128) ? -128 : diff);
    if (!m) m_integ = 0;
    else begin
      isum = m_integ + e;
      if (isum <= 131071 && isum >= -131072) m_integ = isum;
    end
    return e*PC + (m_integ >>> 6) + s*DC;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; err_vld = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    hist.delete();
    m_integ = 0;
  endtask

  // Issue one sample at a negedge and check the cycle-exact response.
  task automatic send(input int e, input bit m, input int exp, input string nm);
    err_sat = 10'(e); moving = m; err_vld = 1'b1;
    @(negedge clk);
    err_vld = 1'b0;
    chk({nm, " busy@E0"}, busy, 1);
    chk({nm, " vld@E0"}, pid_vld, 0);
    @(negedge clk);
    chk({nm, " busy@E1"}, busy, 1);
    @(negedge clk);
    chk({nm, " busy@E2"}, busy, 1);
    chk({nm, " vld@E2"}, pid_vld, 0);
    @(negedge clk);
    chk({nm, " busy@E3"}, busy, 0);
    chk({nm, " vld@E3"}, pid_vld, 1);
    chk({nm, " pid"}, spid(), exp);
  endtask

  vec_t tbl[7];
  int x, y, seen;

  initial begin
    rst_n = 1'b0; err_vld = 1'b0; moving = 1'b0; err_sat = '0;
    tbl[0] = '{1'b1, 100,  1'b1, 1501};
    tbl[1] = '{1'b1, 511,  1'b1, 4984};
    tbl[2] = '{1'b1, -512, 1'b1, -5000};
    tbl[3] = '{1'b1, 5,    1'b1, 75};
    tbl[4] = '{1'b0, 5,    1'b1, 75};
    tbl[5] = '{1'b0, 5,    1'b1, 75};
    tbl[6] = '{1'b0, 5,    1'b1, 40};

    do_reset();
    chk("rst busy", busy, 0);
    chk("rst pid", spid(), 0);
    chk("rst vld", pid_vld, 0);
    chk("rst ovr", ovr, 0);

    // Directed table; model kept in step so later sequences stay aligned.
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].rst) do_reset();
      x = model_step(tbl[i].err, tbl[i].mov);
      send(tbl[i].err, tbl[i].mov, tbl[i].exp_pid, $sformatf("tbl%0d", i));
    end

    // Samples offered at E1 and E2 are dropped with ovr pulses.
    do_reset();
    x = model_step(37, 1'b1);
    err_sat = 10'(37); moving = 1'b1; err_vld = 1'b1;
    @(negedge clk);
    err_sat = 10'(-200);
    chk("ovr@E0", ovr, 0);
    @(negedge clk);
    chk("ovr@E1", ovr, 1);
    @(negedge clk);
    chk("ovr@E2", ovr, 1);
    err_vld = 1'b0;
    @(negedge clk);
    chk("ovr@E3", ovr, 0);
    chk("ovr vld", pid_vld, 1);
    chk("ovr pid", spid(), x);
    y = model_step(-3, 1'b1);
    send(-3, 1'b1, y, "after_ovr");

    // Reset landing on E2 abandons the computation.
    err_sat = 10'(50); moving = 1'b1; err_vld = 1'b1;
    @(negedge clk);
    err_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    hist.delete(); m_integ = 0;
    chk("midrst busy", busy, 0);
    chk("midrst pid", spid(), 0);
    chk("midrst vld", pid_vld, 0);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (pid_vld) seen++;
    end
    chk("midrst no vld", seen, 0);

    // A low pulse on rst_n between edges must be ignored.
    x = model_step(100, 1'b1);
    send(100, 1'b1, x, "pre_glitch");
    @(negedge clk);
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("glitch pid", spid(), 1501);
    chk("glitch busy", busy, 0);

    // Integrator saturating hold, then cleared by moving=0.
    do_reset();
    for (int k = 1; k <= 257; k++) begin
      x = model_step(511, 1'b1);
      send(511, 1'b1, x, $sformatf("isat%0d", k));
    end
    chk("isat integ", int'(dut.integ_q), 130816);
    chk("isat pid", spid(), 6132);
    x = model_step(511, 1'b0);
    send(511, 1'b0, x, "iclr");
    chk("iclr pid", spid(), 4088);
    chk("iclr integ", int'(dut.integ_q), 0);

    // Random samples with random idle gaps.
    do_reset();
    for (int k = 0; k < 60; k++) begin
      int e;
      bit m;
      e = int'($urandom_range(0, 1023)) - 512;
      m = ($urandom_range(0, 7) != 0);
      x = model_step(e, m);
      send(e, m, x, $sformatf("rnd%0d", k));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
